// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-tick divider, h/v counters,
// registered sync/de/colour outputs one pixel behind the request, strobes and frame count.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   CLK_DIV  = 4,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   COLOR_W  = 12,
  parameter int   FRAME_W  = 16,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  H_W      = $clog2(H_TOTAL),
  localparam int  V_W      = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COLOR_W-1:0] pix_color,
  output logic [H_W-1:0]     req_x,
  output logic [V_W-1:0]     req_y,
  output logic               req_valid,
  output logic               pix_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] color,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST    = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT     = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   H_SYNC_LO = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   H_SYNC_HI = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0]   V_LAST    = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_ACT     = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   V_SYNC_LO = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   V_SYNC_HI = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [H_W-1:0]     h_cnt_q, h_cnt_d;
  logic [V_W-1:0]     v_cnt_q, v_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               hsync_q, vsync_q, de_q;
  logic [COLOR_W-1:0] color_q;
  logic               line_start_q, frame_start_q;

  logic h_wrap, v_wrap, h_in_sync, v_in_sync;

  assign pix_tick  = en && (div_cnt_q == DIV_LAST);
  assign req_x     = h_cnt_q;
  assign req_y     = v_cnt_q;
  assign req_valid = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

  always_comb begin
    h_wrap      = (h_cnt_q == H_LAST);
    v_wrap      = (v_cnt_q == V_LAST);
    h_in_sync   = (h_cnt_q >= H_SYNC_LO) && (h_cnt_q <= H_SYNC_HI);
    v_in_sync   = (v_cnt_q >= V_SYNC_LO) && (v_cnt_q <= V_SYNC_HI);
    div_cnt_d   = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    h_cnt_d     = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
      if (v_wrap) frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  // Counters and outputs move only on the tick edge, so en=0 freezes everything
  // except the strobes, which are single-clock pulses by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_cnt_q   <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      color_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      if (en) div_cnt_q <= div_cnt_d;
      line_start_q  <= pix_tick && (h_cnt_q == '0);
      frame_start_q <= pix_tick && (h_cnt_q == '0) && (v_cnt_q == '0);
      if (pix_tick) begin
        h_cnt_q     <= h_cnt_d;
        v_cnt_q     <= v_cnt_d;
        frame_cnt_q <= frame_cnt_d;
        hsync_q     <= h_in_sync ? HS_POL : ~HS_POL;
        vsync_q     <= v_in_sync ? VS_POL : ~VS_POL;
        de_q        <= req_valid;
        color_q     <= req_valid ? pix_color : '0;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign color       = color_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
